// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetch stage with stall, redirect and decoder field slicing
// Ports:
//   clk, nReset                 clock, asynchronous active-low reset
//   imemReq, imemAddr           one-cycle fetch strobe and word-aligned address
//   imemRvalid, imemRdata       instruction memory response
//   stall                       downstream hold of the presented instruction
//   redirect, redirectPc        taken branch/jump and its target
//   instr, pc, instrValid       registered instruction, its address, and valid
//   opcode, ctrl, illegal       decoder fields sliced from instr
module fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            nReset,
    output logic            imemReq,
    output logic [XLEN-1:0] imemAddr,
    input  logic            imemRvalid,
    input  logic [31:0]     imemRdata,
    input  logic            stall,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirectPc,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] pc,
    output logic            instrValid,
    output logic [4:0]      opcode,
    output logic [3:0]      ctrl,
    output logic            illegal
);
    typedef enum logic [1:0] {IDLE, FETCH, WAIT, HOLD} state_t;
    localparam logic [4:0] OP = 5'b01100;
    localparam logic [4:0] OPIMM = 5'b00100;
    state_t state, state_d;
    logic [XLEN-1:0] fetch_pc, fetch_pc_d;
    logic discard, discard_d, valid_d, rsp, capture, redir, pend;
    assign redir = redirect && state != IDLE;
    assign rsp = state == WAIT && imemRvalid;
    assign capture = rsp && !discard && !redir;
    // a request is still in flight after this cycle: issued now, or waited on without a response
    assign pend = state == FETCH || (state == WAIT && !imemRvalid);
    always_comb begin
        state_d = state;
        case (state)
            IDLE:  state_d = FETCH;
            FETCH: state_d = WAIT;
            WAIT:  state_d = rsp ? ((capture && stall) ? HOLD : FETCH) : WAIT;
            HOLD:  state_d = stall ? HOLD : FETCH;
        endcase
        discard_d = rsp ? 1'b0 : discard;
        fetch_pc_d = capture ? fetch_pc + XLEN'(4) : fetch_pc;
        valid_d = capture || (instrValid && stall);
        if (redir) begin
            state_d = pend ? WAIT : FETCH;
            discard_d = pend;
            fetch_pc_d = redirectPc & ~XLEN'(3);
            valid_d = 1'b0;
        end
    end
    always_ff @(posedge clk or negedge nReset)
        if (!nReset) state <= IDLE;
        else state <= state_d;
    always_ff @(posedge clk or negedge nReset)
        if (!nReset) begin
            fetch_pc   <= RESET_PC;
            discard    <= 1'b0;
            instrValid <= 1'b0;
            instr      <= 32'h0000_0013;
            pc         <= RESET_PC;
        end else begin
            fetch_pc   <= fetch_pc_d;
            discard    <= discard_d;
            instrValid <= valid_d;
            if (capture) begin
                instr <= imemRdata;
                pc    <= fetch_pc;
            end
        end
    assign imemReq = state == FETCH;
    assign imemAddr = fetch_pc & ~XLEN'(3);
    assign opcode = instr[6:2];
    // funct7 bit 5 only selects SUB/SRA for register ops and shift-immediates; elsewhere it is immediate data
    assign ctrl = {instr[30] && (opcode == OP || (opcode == OPIMM && instr[14:12] == 3'b101)), instr[14:12]};
    assign illegal = instr[1:0] != 2'b11;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized scoreboard bench for fetch_unit against a transaction-level memory/pipeline model
module tb_fetch_unit;
    localparam logic [31:0] RST_PC = 32'h0000_0000;
    logic        clk, nReset, imemReq, imemRvalid, stall, redirect, instrValid, illegal;
    logic [31:0] imemAddr, imemRdata, redirectPc, instr, pc;
    logic [4:0]  opcode;
    logic [3:0]  ctrl;
    fetch_unit #(.XLEN(32), .RESET_PC(RST_PC)) dut (
        .clk(clk), .nReset(nReset), .imemReq(imemReq), .imemAddr(imemAddr),
        .imemRvalid(imemRvalid), .imemRdata(imemRdata), .stall(stall),
        .redirect(redirect), .redirectPc(redirectPc), .instr(instr), .pc(pc),
        .instrValid(instrValid), .opcode(opcode), .ctrl(ctrl), .illegal(illegal)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    typedef struct packed {logic [31:0] a; logic [31:0] d;} cap_t;
    cap_t sb[$];
    int tests = 0;
    int fails = 0;
    logic [31:0] words[6] = '{32'h00000013, 32'h00A00093, 32'h40005013, 32'h40000013, 32'h40000033, 32'h00000001};
    logic [31:0] tgts[4] = '{32'h00000103, 32'hFFFFFFFC, 32'hFFFFFFF8, 32'h00000000};
    logic        p_req, p_rv, p_stall, p_redir, outst, hold, dropped, rv_now;
    logic [31:0] p_addr, p_data, p_tgt, cur_addr, exp_pc;
    int          cnt, since_rst, stale;
    function automatic void chk(string n, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endfunction
    // ALU control: funct3, plus funct7[5] for R-type ops and shift-immediates only
    function automatic logic [3:0] exp_ctrl(logic [31:0] w);
        logic alt;
        alt = w[6:2] == 5'b01100 || (w[6:2] == 5'b00100 && w[14:12] == 3'b101);
        return {alt & w[30], w[14:12]};
    endfunction
    // monitor: the presented instruction is the most recent capture not yet consumed or flushed
    initial begin : mon
        cap_t c;
        forever begin
            @(negedge clk);
            chk("instrValid", 32'(instrValid), 32'(sb.size() != 0));
            if (sb.size() != 0) begin
                c = sb[$];
                chk("instr", instr, c.d);
                chk("pc", pc, c.a);
                chk("opcode", 32'(opcode), 32'(c.d[6:2]));
                chk("ctrl", 32'(ctrl), 32'(exp_ctrl(c.d)));
                chk("illegal", 32'(illegal), 32'(c.d[1:0] != 2'b11));
            end
            if (nReset && ((sb.size() != 0 && !stall) || redirect)) sb.delete();
        end
    end
    // one cycle of the model, run 2ns after each rising edge
    task automatic step();
        if (!p_stall) hold = 1'b0;
        if (p_rv && outst) begin
            outst = 1'b0;
            if (!dropped && !p_redir) begin
                sb.push_back({cur_addr, p_data});
                exp_pc = cur_addr + 32'd4;
                hold = p_stall;
            end
        end
        if (p_req) begin
            outst = 1'b1;
            dropped = p_redir;
            cur_addr = p_addr;
            cnt = int'($urandom_range(1, 3));
        end else if (p_redir && outst) dropped = 1'b1;
        if (p_redir) begin
            exp_pc = p_tgt & ~32'h3;
            hold = 1'b0;
        end
        chk("imemReq", 32'(imemReq), 32'(!outst && !hold && since_rst >= 1));
        if (imemReq) chk("imemAddr", imemAddr, exp_pc);
        rv_now = 1'b0;
        if (stale > 0) begin
            stale--;
            rv_now = 1'b1;
        end else if (outst) begin
            cnt--;
            rv_now = cnt == 0;
        end
        imemRvalid = rv_now;
        imemRdata = stale > 0 || !outst ? 32'hDEADBEEF : ($urandom_range(0, 2) != 0 ? words[$urandom_range(0, 5)] : $urandom);
        stall = $urandom_range(0, 3) == 0;
        redirect = since_rst >= 2 && $urandom_range(0, 19) == 0;
        redirectPc = $urandom_range(0, 1) != 0 ? tgts[$urandom_range(0, 3)] : $urandom;
        p_req = imemReq;
        p_addr = imemAddr;
        p_rv = imemRvalid;
        p_data = imemRdata;
        p_stall = stall;
        p_redir = redirect;
        p_tgt = redirectPc;
        since_rst++;
    endtask
    // asserted mid-cycle; stale responses are pulsed right after release
    task automatic do_reset();
        nReset = 1'b0;
        imemRvalid = 1'b0;
        stall = 1'b0;
        redirect = 1'b0;
        sb.delete();
        repeat (3) begin
            @(posedge clk);
            #2;
            chk("rst imemReq", 32'(imemReq), 32'd0);
            chk("rst imemAddr", imemAddr, RST_PC);
            chk("rst pc", pc, RST_PC);
            chk("rst instr", instr, 32'h00000013);
            chk("rst opcode", 32'(opcode), 32'h4);
            chk("rst ctrl", 32'(ctrl), 32'h0);
            chk("rst instrValid", 32'(instrValid), 32'd0);
            chk("rst illegal", 32'(illegal), 32'd0);
        end
        nReset = 1'b1;
        since_rst = 0;
        outst = 1'b0;
        hold = 1'b0;
        dropped = 1'b0;
        exp_pc = RST_PC;
        {p_req, p_rv, p_stall, p_redir} = '0;
        stale = 2;
    endtask
    initial begin
        nReset = 1'b0;
        imemRvalid = 1'b0;
        imemRdata = '0;
        stall = 1'b0;
        redirect = 1'b0;
        redirectPc = '0;
        @(posedge clk);
        #2;
        do_reset();
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 1500; i++) begin
                step();
                @(posedge clk);
                #2;
            end
            for (int i = 0; i < 20; i++) begin
                step();
                if (outst && !imemRvalid) break;
                @(posedge clk);
                #2;
            end
            do_reset();
        end
        for (int i = 0; i < 200; i++) begin
            step();
            @(posedge clk);
            #2;
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
